test_harness_ctrl: RTL
======================

TEST_HARNESS_CTRL -- requirements
Module: test_harness_ctrl

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 64, meaning the program buffer size in 32-bit words (minimum 1).
REQ-002 The block SHALL expose parameter BASE_ADDR, default 32'h0000_0004, meaning the byte address of program word 0.
REQ-003 The block SHALL expose parameter TIMEOUT_CYCLES, default 1000, meaning the maximum RUN-state cycles before a timeout failure.
REQ-004 The block SHALL expose parameter RESET_CYCLES, default 2, meaning the number of cycles cpu_reset stays high in RELEASE.
REQ-005 The block SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports: start  in  1  run request; prog_wr_en  in  1  buffer write strobe; prog_wr_idx  in  clog2(DEPTH)  buffer index; prog_wr_data  in  32  program word; prog_len  in  clog2(DEPTH+1)  words to load; expected_v0  in  32  golden result.
REQ-007 The block SHALL have Avalon master ports: address  out  32; write  out  1; writedata  out  32; byteenable  out  4; waitrequest  in  1.
REQ-008 The block SHALL have CPU ports: cpu_reset  out  1  active-high CPU reset; cpu_active  in  1  CPU active; register_v0  in  32  CPU result.
REQ-009 The block SHALL have status ports: busy  out  1; done  out  1; pass  out  1; fail_timeout  out  1; fail_value  out  1; cycle_count  out  32  RUN cycles elapsed.

Function
REQ-010 The FSM SHALL have states IDLE, LOAD, RELEASE, RUN, CHECK and DONE.
REQ-011 In IDLE, a prog_wr_en pulse SHALL write prog_wr_data into buffer[prog_wr_idx] at the clock edge; prog_wr_en outside IDLE/DONE SHALL be ignored.
REQ-012 Start in IDLE or DONE SHALL capture min(prog_len, DEPTH) as the word count and expected_v0, clear done/pass/fail flags and cycle_count, and enter LOAD (or RELEASE if the count is 0).
REQ-013 Start in any other state SHALL be ignored.
REQ-014 In LOAD, word i SHALL be driven with write=1, address=BASE_ADDR+4*i, writedata=buffer[i], byteenable=4'hF.
REQ-015 While waitrequest=1, address, writedata and write SHALL be held stable; i SHALL advance only on a cycle with write=1 and waitrequest=0.
REQ-016 After the last word is accepted, write SHALL drop to 0 on the next cycle and the FSM SHALL enter RELEASE.
REQ-017 RELEASE SHALL hold cpu_reset=1 for exactly RESET_CYCLES cycles, clear the cpu_active edge-history register to 0, then enter RUN.
REQ-018 In RUN, cpu_reset SHALL be 0 and cycle_count SHALL increment by 1 per cycle, saturating at 32'hFFFF_FFFF.
REQ-019 A falling edge of cpu_active (registered previous value 1, current value 0) in RUN SHALL cause entry to CHECK, sampling register_v0 in that same cycle.
REQ-020 If cycle_count reaches TIMEOUT_CYCLES in RUN without a falling edge, the block SHALL enter DONE with fail_timeout=1.
REQ-021 A falling edge coincident with the timeout cycle SHALL take priority, so CHECK is entered.
REQ-022 CHECK SHALL last one cycle and then enter DONE with pass=1 if the sampled v0 equals the captured expected value, otherwise fail_value=1.
REQ-023 In DONE, cpu_reset SHALL be 1, done=1, and the flags and cycle_count SHALL hold until the next accepted start.
REQ-024 Busy SHALL be 1 in LOAD, RELEASE, RUN and CHECK, and 0 otherwise.
REQ-025 The pass, fail_timeout and fail_value flags SHALL be mutually exclusive.

Reset
REQ-026 Asserting reset (reset=0) SHALL immediately force the state to IDLE, write=0, address=0, writedata=0, byteenable=0, cpu_reset=1, busy=0, done=0, pass=0, fail_timeout=0, fail_value=0 and cycle_count=0.
REQ-027 Reset SHALL NOT be required to clear buffer contents.
REQ-028 Reset asserted mid-LOAD SHALL abandon the transfer with write=0 within the same cycle.

Verification
REQ-029 Scenario: load 2403FFF0, 00031C00, 2404FFFF, 00042400, 0064102A, 00000008 with prog_len=6 and expected_v0=1, then start -> six writes at addresses 0x04..0x18 in order; CPU v0=1 at the active falling edge -> done=1, pass=1.
REQ-030 Scenario: waitrequest held high for 3 cycles on every write -> each word written once, with address and writedata stable throughout each stall.
REQ-031 Scenario: cpu_active held at 1 with TIMEOUT_CYCLES=1000 -> fail_timeout=1 and cycle_count=1000, with pass=0.
REQ-032 Scenario: expected_v0=1 and register_v0=0 at the active falling edge -> fail_value=1 and pass=0.
REQ-033 Scenario: prog_len=0 -> no writes, RELEASE is entered directly, and cpu_reset is high for exactly 2 cycles.
REQ-034 Scenario: reset asserted during the third LOAD write, then start again -> write is 0 during reset, all outputs show their reset values, and the second run restarts at BASE_ADDR.

Source files
------------

// File: rtl/test_harness_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : test_harness_ctrl
// Purpose  : Program-load and run controller for a CPU under test. It buffers
//            a program written through a simple write port, copies it into CPU
//            memory over an Avalon-MM master, releases the CPU from reset,
//            waits for the CPU to go inactive (or time out) and compares the
//            CPU result register against a golden value.
// Ports    : clk, reset (async, active-low)
//            start, prog_wr_en/idx/data, prog_len, expected_v0 - control/program
//            address, write, writedata, byteenable, waitrequest - Avalon master
//            cpu_reset, cpu_active, register_v0                 - CPU handshake
//            busy, done, pass, fail_timeout, fail_value,
//            cycle_count                                        - status
// Revision : 1.0 - initial release
// ============================================================================
module test_harness_ctrl #(
    parameter int unsigned DEPTH          = 64,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0004,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned RESET_CYCLES   = 2,
    localparam int unsigned IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LEN_W         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    // control / program buffer
    input  logic             start,
    input  logic             prog_wr_en,
    input  logic [IDX_W-1:0] prog_wr_idx,
    input  logic [31:0]      prog_wr_data,
    input  logic [LEN_W-1:0] prog_len,
    input  logic [31:0]      expected_v0,
    // Avalon-MM master
    output logic [31:0]      address,
    output logic             write,
    output logic [31:0]      writedata,
    output logic [3:0]       byteenable,
    input  logic             waitrequest,
    // CPU handshake
    output logic             cpu_reset,
    input  logic             cpu_active,
    input  logic [31:0]      register_v0,
    // status
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail_timeout,
    output logic             fail_value,
    output logic [31:0]      cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    logic [31:0]      r_mem [DEPTH];
    logic [LEN_W-1:0] r_count;       // words to copy for this run
    logic [LEN_W-1:0] r_word;        // index of the word currently on the bus
    logic [31:0]      r_expected;
    logic [31:0]      r_v0;
    logic [31:0]      r_rst_cnt;
    logic             r_active_prev;

    logic [LEN_W-1:0] w_len_clip;
    logic [IDX_W-1:0] w_next_idx;
    logic [31:0]      w_cnt_next;
    logic             w_fall;
    logic             w_rel_done;
    logic             w_timeout;

    assign w_len_clip = (32'(prog_len) > DEPTH) ? LEN_W'(DEPTH) : prog_len;
    assign w_next_idx = IDX_W'(r_word + LEN_W'(1));
    assign w_cnt_next = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    assign w_fall     = r_active_prev && !cpu_active;
    // A zero RESET_CYCLES still spends one cycle in RELEASE.
    assign w_rel_done = (r_rst_cnt + 32'd1) >= 32'(RESET_CYCLES);
    assign w_timeout  = w_cnt_next >= 32'(TIMEOUT_CYCLES);

    // Program buffer: no reset, writable only while the harness is parked.
    always_ff @(posedge clk) begin
        if (prog_wr_en && (r_state == S_IDLE || r_state == S_DONE) &&
            (32'(prog_wr_idx) < DEPTH)) begin
            r_mem[prog_wr_idx] <= prog_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_word        <= '0;
            r_expected    <= '0;
            r_v0          <= '0;
            r_rst_cnt     <= '0;
            r_active_prev <= 1'b0;
            address       <= '0;
            write         <= 1'b0;
            writedata     <= '0;
            byteenable    <= '0;
            cpu_reset     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail_timeout  <= 1'b0;
            fail_value    <= 1'b0;
            cycle_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_count      <= w_len_clip;
                        r_expected   <= expected_v0;
                        r_word       <= '0;
                        r_rst_cnt    <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        fail_timeout <= 1'b0;
                        fail_value   <= 1'b0;
                        cycle_count  <= '0;
                        if (w_len_clip == '0) begin
                            r_state <= S_RELEASE;
                        end else begin
                            // First word goes on the bus in the first LOAD cycle.
                            r_state    <= S_LOAD;
                            write      <= 1'b1;
                            address    <= BASE_ADDR;
                            writedata  <= r_mem[0];
                            byteenable <= 4'hF;
                        end
                    end
                end
                S_LOAD: begin
                    // write is always 1 here; bus fields hold while stalled.
                    if (!waitrequest) begin
                        if (r_word == r_count - LEN_W'(1)) begin
                            write      <= 1'b0;
                            address    <= '0;
                            writedata  <= '0;
                            byteenable <= '0;
                            r_state    <= S_RELEASE;
                        end else begin
                            r_word    <= r_word + LEN_W'(1);
                            address   <= address + 32'd4;
                            writedata <= r_mem[w_next_idx];
                        end
                    end
                end
                S_RELEASE: begin
                    // History cleared so a stale high cannot fake an edge in RUN.
                    r_active_prev <= 1'b0;
                    if (w_rel_done) begin
                        cpu_reset <= 1'b0;
                        r_state   <= S_RUN;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    r_active_prev <= cpu_active;
                    cycle_count   <= w_cnt_next;
                    // Falling edge wins over a coincident timeout.
                    if (w_fall) begin
                        r_v0      <= register_v0;
                        cpu_reset <= 1'b1;
                        r_state   <= S_CHECK;
                    end else if (w_timeout) begin
                        cpu_reset    <= 1'b1;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        fail_timeout <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_CHECK: begin
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    pass       <= (r_v0 == r_expected);
                    fail_value <= (r_v0 != r_expected);
                    r_state    <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
